// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Receives 8N1 serial frames from the host. The line is sampled at DIV clocks
//   per bit, and the receiver hands each byte to the command scanner over a
//   vld_rx/rdy_rx handshake. It flags bad stop bits (ferr) and bytes lost
//   because the holding register was still full (ovf).
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> 8E1 frames with an extra perr output
//     undefined -> 8N1 only, and the perr port is absent
//
// Parameters
//   DIV          clocks per bit (>= 4); the start bit is checked at DIV/2
//   SYNC_STAGES  depth of the rxd synchroniser (>= 2)
//
// Ports
//   clk     in   single clock, all logic on posedge
//   rstn    in   asynchronous active-low reset
//   rxd     in   serial line, idle high, asynchronous to clk
//   rdy_rx  in   consumer accepts d_rx this cycle when vld_rx=1
//   vld_rx  out  d_rx holds an unconsumed byte (registered)
//   d_rx    out  received byte, stable while vld_rx=1
//   ferr    out  1-cycle pulse: stop bit sampled low, byte discarded
//   ovf     out  1-cycle pulse: completed byte lost, holding register full
//   perr    out  (parity build only) 1-cycle pulse: even-parity error
module uart_rx_frame #(
  parameter int DIV         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rdy_rx,
  output logic       vld_rx,
  output logic [7:0] d_rx,
  output logic       ferr,
  output logic       ovf
`ifdef UART_RX_PARITY_EN
  ,
  output logic       perr
`endif
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [TW-1:0]          tick_q;
  logic [2:0]             bit_q;
  logic [7:0]             sr_q;
  logic                   vld_q;
  logic [7:0]             d_q;
  logic                   ferr_q;
  logic                   ovf_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   perr_q;
`endif

  logic rs;
  logic tick_done;

  assign rs        = sync_q[SYNC_STAGES-1];
  assign tick_done = (tick_q == TICK_LAST);

  // Synchroniser: resets to the idle-high line level so a reset never looks
  // like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      vld_q   <= 1'b0;
      d_q     <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // A consumed byte drops vld; a load later in this block overrides this.
      if (vld_q && rdy_rx) begin
        vld_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          tick_q <= '0;
          bit_q  <= '0;
          if (!rs) begin
            state_q <= S_START;
          end
        end

        // Re-check the start bit at mid-bit to reject short glitches.
        S_START: begin
          if (tick_q == TICK_MID) begin
            tick_q  <= '0;
            state_q <= rs ? S_IDLE : S_DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        S_DATA: begin
          if (tick_done) begin
            tick_q <= '0;
            sr_q   <= {rs, sr_q[7:1]};
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (tick_done) begin
            tick_q  <= '0;
            par_q   <= rs;
            state_q <= S_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (tick_done) begin
            tick_q <= '0;
            if (!rs) begin
              // A bad stop bit wins over overrun; the byte is never loaded.
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
`ifdef UART_RX_PARITY_EN
              perr_q  <= ^{sr_q, par_q};
`endif
            end
`ifdef UART_RX_PARITY_EN
            else if (^{sr_q, par_q}) begin
              perr_q  <= 1'b1;
              state_q <= S_IDLE;
            end
`endif
            else begin
              state_q <= S_IDLE;
              if (!vld_q || rdy_rx) begin
                d_q   <= sr_q;
                vld_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        // A line held low (break) must return high before a new frame counts.
        S_BREAK: begin
          if (rs) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign vld_rx = vld_q;
  assign d_rx   = d_q;
  assign ferr   = ferr_q;
  assign ovf    = ovf_q;
`ifdef UART_RX_PARITY_EN
  assign perr   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  localparam int DIV  = 16;
  localparam int SYNC = 2;
  // Clock edges from the start of the stop bit on the pin to the stop sample:
  // synchroniser delay, one cycle for IDLE to see the edge, and half a bit.
  localparam int STOP_WAIT = SYNC + 1 + DIV / 2;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       rxd    = 1'b1;
  logic       rdy_rx = 1'b0;
  logic       vld_rx;
  logic [7:0] d_rx;
  logic       ferr;
  logic       ovf;

  always #5 clk = ~clk;

  uart_rx_frame #(.DIV(DIV), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rxd    (rxd),
    .rdy_rx (rdy_rx),
    .vld_rx (vld_rx),
    .d_rx   (d_rx),
    .ferr   (ferr),
    .ovf    (ovf)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: the holding register as seen from outside.
  bit         m_held    = 1'b0;
  logic [7:0] m_last    = 8'h00;
  int         exp_ferr  = 0;
  int         exp_ovf   = 0;
  int         exp_loads = 0;

  // Event counters gathered from the DUT outputs.
  int   seen_ferr  = 0;
  int   seen_ovf   = 0;
  int   seen_loads = 0;
  logic vld_prev   = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (ferr) seen_ferr <= seen_ferr + 1;
      if (ovf) seen_ovf <= seen_ovf + 1;
      if (vld_rx && !vld_prev) seen_loads <= seen_loads + 1;
    end
    vld_prev <= vld_rx;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting just after a posedge, and checks the outcome at
  // the stop sample and one cycle later. Leaves rxd high when it returns.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rdy,
                            input int hold_low);
    logic [9:0] bits;
    bits   = {stop_ok, b, 1'b0};
    rdy_rx = rdy;
    if (rdy) m_held = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rxd = bits[i];
      step(DIV);
    end
    rxd = bits[9];
    step(STOP_WAIT);
    @(negedge clk);
    if (!stop_ok) begin
      exp_ferr++;
      check_val("ferr_at_stop", ferr, 1);
      check_val("ovf_at_badstop", ovf, 0);
      check_val("vld_at_badstop", vld_rx, m_held);
      check_val("d_at_badstop", d_rx, m_last);
    end else if (m_held) begin
      exp_ovf++;
      check_val("ovf_at_stop", ovf, 1);
      check_val("ferr_at_ovf", ferr, 0);
      check_val("vld_at_ovf", vld_rx, 1);
      check_val("d_kept_at_ovf", d_rx, m_last);
    end else begin
      exp_loads++;
      m_held = 1'b1;
      m_last = b;
      check_val("vld_at_load", vld_rx, 1);
      check_val("d_at_load", d_rx, b);
      check_val("ferr_at_load", ferr, 0);
      check_val("ovf_at_load", ovf, 0);
    end
    @(posedge clk);
    #1;
    if (rdy) m_held = 1'b0;
    @(negedge clk);
    check_val("ferr_pulse_end", ferr, 0);
    check_val("ovf_pulse_end", ovf, 0);
    check_val("vld_after_stop", vld_rx, m_held);
    step(DIV - STOP_WAIT - 1);
    if (hold_low > 0) step(hold_low);
    rxd = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    bit         rdy;
    int         hold;
    int         gap;

    // Reset state.
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    @(negedge clk);
    check_val("rst_vld", vld_rx, 0);
    check_val("rst_d", d_rx, 0);
    check_val("rst_ferr", ferr, 0);
    check_val("rst_ovf", ovf, 0);
    step(5);

    // Single byte, consumer ready.
    send_frame(8'h31, 1'b1, 1'b1, 0);
    step(4);

    // Back-to-back frames.
    send_frame(8'h55, 1'b1, 1'b1, 0);
    send_frame(8'hAA, 1'b1, 1'b1, 0);
    step(4);

    // Consumer stalled: second byte overruns.
    send_frame(8'h12, 1'b1, 1'b0, 0);
    step(3);
    send_frame(8'h34, 1'b1, 1'b0, 0);
    rdy_rx = 1'b1;
    @(posedge clk);
    #1;
    m_held = 1'b0;
    @(negedge clk);
    check_val("vld_after_take", vld_rx, 0);
    check_val("d_after_take", d_rx, 8'h12);
    step(3);

    // Bad stop followed by a long break: exactly one ferr, no byte.
    send_frame(8'h7E, 1'b0, 1'b1, 100);
    step(10);
    check_val("ferr_count_break", seen_ferr, exp_ferr);
    send_frame(8'h41, 1'b1, 1'b1, 0);
    step(5);

    // Short low glitch on an idle line.
    rdy_rx = 1'b0;
    rxd    = 1'b0;
    step(4);
    rxd    = 1'b1;
    step(60);
    @(negedge clk);
    check_val("glitch_vld", vld_rx, m_held);
    check_val("glitch_d", d_rx, m_last);
    step(1);

    // Reset in the middle of a frame.
    b   = 8'hC3;
    rxd = 1'b0;
    step(DIV);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      step(DIV);
    end
    rstn = 1'b0;
    step(2);
    rxd  = 1'b1;
    rstn = 1'b1;
    m_held = 1'b0;
    m_last = 8'h00;
    @(negedge clk);
    check_val("midrst_vld", vld_rx, 0);
    check_val("midrst_d", d_rx, 0);
    check_val("midrst_ferr", ferr, 0);
    check_val("midrst_ovf", ovf, 0);
    step(200);
    @(negedge clk);
    check_val("postrst_vld", vld_rx, 0);
    step(1);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    step(3);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      hold = ok ? 0 : $urandom_range(0, 40);
      gap  = ok ? $urandom_range(0, 12) : $urandom_range(1, 12);
      send_frame(b, ok, rdy, hold);
      if (gap > 0) step(gap);
    end

    step(40);
    check_val("ferr_count", seen_ferr, exp_ferr);
    check_val("ovf_count", seen_ovf, exp_ovf);
    check_val("load_count", seen_loads, exp_loads);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
